// File: rtl/draw_scroll_background.sv
// -----------------------------------------------------------------------------
// draw_scroll_background
//   Tiled-background stage of the VGA draw chain. Fills the rectangle
//   [H_MIN,H_MAX) x [V_MIN,V_MAX) with a repeating 2^TILE_LOG2 square tile
//   read from an external tile ROM, with frame-synchronous scrolling,
//   per-frame auto-scroll, a frame-latched enable and optional colour-key
//   transparency. Pixels outside the rectangle pass through unchanged.
//
// Ports:
//   i_pclk, i_rst                     pixel clock, async active-high reset
//   i_hcount, i_vcount                timing counters (12 bit)
//   i_hsync, i_vsync, i_hblnk, i_vblnk timing strobes
//   i_rgb                             upstream pixel
//   i_rom_rgb                         tile ROM data, ROM_LATENCY after address
//   i_scroll_x, i_scroll_y            requested scroll offset
//   i_scroll_valid / o_scroll_ready   scroll request handshake
//   i_auto_dx, i_auto_dy              signed per-frame auto-scroll step
//   i_enable                          background enable request (latched at FB)
//   o_hcount..o_vblnk, o_rgb          timing and pixel, ROM_LATENCY+1 cycles late
//   o_rom_addr                        tile ROM address {row, column}
//   o_frame_tick                      one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module draw_scroll_background #(
  parameter int unsigned H_MIN          = 0,
  parameter int unsigned H_MAX          = 1920,
  parameter int unsigned V_MIN          = 0,
  parameter int unsigned V_MAX          = 1080,
  parameter int unsigned TILE_LOG2      = 6,
  parameter int unsigned ROM_LATENCY    = 1,
  parameter logic        TRANSPARENT_EN = 1'b1,
  parameter logic [11:0] KEY_RGB        = 12'hF0F
) (
  input  logic                     i_pclk,
  input  logic                     i_rst,
  input  logic [11:0]              i_hcount,
  input  logic [11:0]              i_vcount,
  input  logic                     i_hsync,
  input  logic                     i_vsync,
  input  logic                     i_hblnk,
  input  logic                     i_vblnk,
  input  logic [11:0]              i_rgb,
  input  logic [11:0]              i_rom_rgb,
  input  logic [TILE_LOG2-1:0]     i_scroll_x,
  input  logic [TILE_LOG2-1:0]     i_scroll_y,
  input  logic                     i_scroll_valid,
  output logic                     o_scroll_ready,
  input  logic signed [3:0]        i_auto_dx,
  input  logic signed [3:0]        i_auto_dy,
  input  logic                     i_enable,
  output logic [11:0]              o_hcount,
  output logic [11:0]              o_vcount,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic                     o_hblnk,
  output logic                     o_vblnk,
  output logic [11:0]              o_rgb,
  output logic [2*TILE_LOG2-1:0]   o_rom_addr,
  output logic                     o_frame_tick
);

  localparam logic [11:0] H_MIN12  = 12'(H_MIN);
  localparam logic [11:0] V_MIN12  = 12'(V_MIN);
  localparam logic [11:0] H_SPAN12 = 12'(H_MAX - H_MIN);
  localparam logic [11:0] V_SPAN12 = 12'(V_MAX - V_MIN);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } tim_t;

  state_t               state;
  logic                 vblnk_q;
  logic                 fb;
  logic                 en;
  logic [TILE_LOG2-1:0] act_x;
  logic [TILE_LOG2-1:0] act_y;
  logic [TILE_LOG2-1:0] pend_x;
  logic [TILE_LOG2-1:0] pend_y;
  logic [TILE_LOG2-1:0] dx_t;
  logic [TILE_LOG2-1:0] dy_t;
  logic [TILE_LOG2-1:0] col;
  logic [TILE_LOG2-1:0] row;

  tim_t                 cur;
  tim_t                 pipe [ROM_LATENCY];
  tim_t                 d;
  logic [11:0]          h_off;
  logic [11:0]          v_off;
  logic                 in_rect;
  logic [11:0]          pix;

  // Frame boundary: rising edge of vertical blanking.
  assign fb = i_vblnk & ~vblnk_q;

  // Sign-extend the 4-bit step, then truncate: truncation is exactly the
  // modulo-2^TILE_LOG2 wrap in both directions.
  always_comb begin
    dx_t = TILE_LOG2'(12'(i_auto_dx));
    dy_t = TILE_LOG2'(12'(i_auto_dy));
  end

  always_comb begin
    col = TILE_LOG2'(i_hcount - H_MIN12 + 12'(act_x));
    row = TILE_LOG2'(i_vcount - V_MIN12 + 12'(act_y));
  end

  assign o_rom_addr = {row, col};

  // Scroll handshake, auto-scroll, enable latch and frame tick.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      o_scroll_ready <= 1'b1;
      vblnk_q        <= 1'b0;
      o_frame_tick   <= 1'b0;
      en             <= 1'b0;
      act_x          <= '0;
      act_y          <= '0;
      pend_x         <= '0;
      pend_y         <= '0;
    end else begin
      vblnk_q      <= i_vblnk;
      o_frame_tick <= fb;
      if (fb) begin
        en <= i_enable;
      end
      case (state)
        IDLE: begin
          if (fb) begin
            act_x <= act_x + dx_t;
            act_y <= act_y + dy_t;
          end
          // A request arriving on the FB cycle itself waits for the next FB.
          if (i_scroll_valid) begin
            pend_x         <= i_scroll_x;
            pend_y         <= i_scroll_y;
            state          <= PEND;
            o_scroll_ready <= 1'b0;
          end
        end
        PEND: begin
          // Pending offset replaces this frame's auto-step.
          if (fb) begin
            act_x          <= pend_x;
            act_y          <= pend_y;
            state          <= IDLE;
            o_scroll_ready <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          o_scroll_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cur.hcount = i_hcount;
    cur.vcount = i_vcount;
    cur.hsync  = i_hsync;
    cur.vsync  = i_vsync;
    cur.hblnk  = i_hblnk;
    cur.vblnk  = i_vblnk;
    cur.rgb    = i_rgb;
  end

  assign d = pipe[ROM_LATENCY-1];

  // Unsigned wrap makes counts below the lower bound look huge, so a single
  // compare per axis covers both bounds (valid while the upper bound <= 4096).
  always_comb begin
    h_off   = d.hcount - H_MIN12;
    v_off   = d.vcount - V_MIN12;
    in_rect = (h_off < H_SPAN12) && (v_off < V_SPAN12);
  end

  always_comb begin
    pix = d.rgb;
    if (d.hblnk || d.vblnk) begin
      pix = '0;
    end else if (!en) begin
      pix = d.rgb;
    end else if (in_rect) begin
      if (TRANSPARENT_EN && (i_rom_rgb == KEY_RGB)) begin
        pix = d.rgb;
      end else begin
        pix = i_rom_rgb;
      end
    end
  end

  // Delay line aligned with the ROM read latency, then the output register.
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        pipe[i] <= '0;
      end
      o_hcount <= '0;
      o_vcount <= '0;
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_hblnk  <= 1'b0;
      o_vblnk  <= 1'b0;
      o_rgb    <= '0;
    end else begin
      pipe[0] <= cur;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      o_hcount <= d.hcount;
      o_vcount <= d.vcount;
      o_hsync  <= d.hsync;
      o_vsync  <= d.vsync;
      o_hblnk  <= d.hblnk;
      o_vblnk  <= d.vblnk;
      o_rgb    <= pix;
    end
  end

endmodule

// File: tb/tb_draw_scroll_background.sv
// -----------------------------------------------------------------------------
// tb_draw_scroll_background
//   Directed bench for draw_scroll_background. A small 80x8 frame (active
//   72x6) is generated; three instances share the stimulus:
//     dut1: ROM_LATENCY 1, rectangle [0,70)x[0,6), transparency on
//     dut4: ROM_LATENCY 4, same rectangle
//     dutn: ROM_LATENCY 1, rectangle [4,70)x[1,6), transparency off
//   Tile ROM model: data = addr ^ 12'h3C3, or 12'hF0F while key_mode is set.
//   Upstream pixel: {v[3:0], h[7:0]} ^ 12'h800, or 12'h123 while rgb_fixed.
// -----------------------------------------------------------------------------
module tb_draw_scroll_background;

  logic              clk;
  logic              rst;
  logic [11:0]       hcount, vcount;
  logic              hsync, vsync, hblnk, vblnk;
  logic [11:0]       rgb;
  logic [5:0]        scroll_x, scroll_y;
  logic              scroll_valid;
  logic signed [3:0] auto_dx, auto_dy;
  logic              enable;

  logic [11:0] rom1, rom4, romn;
  logic [11:0] addr1, addr4, addrn;
  logic        ready1, ready4, readyn;
  logic [11:0] o_hcount1, o_vcount1, o_rgb1;
  logic        o_hsync1, o_vsync1, o_hblnk1, o_vblnk1, tick1;
  logic [11:0] o_hcount4, o_vcount4, o_rgb4;
  logic        o_hsync4, o_vsync4, o_hblnk4, o_vblnk4, tick4;
  logic [11:0] o_hcountn, o_vcountn, o_rgbn;
  logic        o_hsyncn, o_vsyncn, o_hblnkn, o_vblnkn, tickn;

  int h, v;
  int checks, errors;
  logic rgb_fixed, key_mode;

  draw_scroll_background #(
    .H_MIN(0), .H_MAX(70), .V_MIN(0), .V_MAX(6),
    .TILE_LOG2(6), .ROM_LATENCY(1), .TRANSPARENT_EN(1'b1), .KEY_RGB(12'hF0F)
  ) dut1 (
    .i_pclk(clk), .i_rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_hsync(hsync), .i_vsync(vsync), .i_hblnk(hblnk), .i_vblnk(vblnk),
    .i_rgb(rgb), .i_rom_rgb(rom1), .i_scroll_x(scroll_x), .i_scroll_y(scroll_y),
    .i_scroll_valid(scroll_valid), .o_scroll_ready(ready1),
    .i_auto_dx(auto_dx), .i_auto_dy(auto_dy), .i_enable(enable),
    .o_hcount(o_hcount1), .o_vcount(o_vcount1), .o_hsync(o_hsync1), .o_vsync(o_vsync1),
    .o_hblnk(o_hblnk1), .o_vblnk(o_vblnk1), .o_rgb(o_rgb1), .o_rom_addr(addr1),
    .o_frame_tick(tick1)
  );

  draw_scroll_background #(
    .H_MIN(0), .H_MAX(70), .V_MIN(0), .V_MAX(6),
    .TILE_LOG2(6), .ROM_LATENCY(4), .TRANSPARENT_EN(1'b1), .KEY_RGB(12'hF0F)
  ) dut4 (
    .i_pclk(clk), .i_rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_hsync(hsync), .i_vsync(vsync), .i_hblnk(hblnk), .i_vblnk(vblnk),
    .i_rgb(rgb), .i_rom_rgb(rom4), .i_scroll_x(scroll_x), .i_scroll_y(scroll_y),
    .i_scroll_valid(scroll_valid), .o_scroll_ready(ready4),
    .i_auto_dx(auto_dx), .i_auto_dy(auto_dy), .i_enable(enable),
    .o_hcount(o_hcount4), .o_vcount(o_vcount4), .o_hsync(o_hsync4), .o_vsync(o_vsync4),
    .o_hblnk(o_hblnk4), .o_vblnk(o_vblnk4), .o_rgb(o_rgb4), .o_rom_addr(addr4),
    .o_frame_tick(tick4)
  );

  draw_scroll_background #(
    .H_MIN(4), .H_MAX(70), .V_MIN(1), .V_MAX(6),
    .TILE_LOG2(6), .ROM_LATENCY(1), .TRANSPARENT_EN(1'b0), .KEY_RGB(12'hF0F)
  ) dutn (
    .i_pclk(clk), .i_rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_hsync(hsync), .i_vsync(vsync), .i_hblnk(hblnk), .i_vblnk(vblnk),
    .i_rgb(rgb), .i_rom_rgb(romn), .i_scroll_x(scroll_x), .i_scroll_y(scroll_y),
    .i_scroll_valid(scroll_valid), .o_scroll_ready(readyn),
    .i_auto_dx(auto_dx), .i_auto_dy(auto_dy), .i_enable(enable),
    .o_hcount(o_hcountn), .o_vcount(o_vcountn), .o_hsync(o_hsyncn), .o_vsync(o_vsyncn),
    .o_hblnk(o_hblnkn), .o_vblnk(o_vblnkn), .o_rgb(o_rgbn), .o_rom_addr(addrn),
    .o_frame_tick(tickn)
  );

  // Tile ROM models with 1 and 4 cycles of read latency.
  logic [11:0] a1_q, an_q;
  logic [11:0] a4_q [4];

  always @(posedge clk) begin
    a1_q    <= addr1;
    an_q    <= addrn;
    a4_q[0] <= addr4;
    for (int i = 1; i < 4; i++) a4_q[i] <= a4_q[i-1];
  end

  assign rom1 = key_mode ? 12'hF0F : (a1_q ^ 12'h3C3);
  assign rom4 = key_mode ? 12'hF0F : (a4_q[3] ^ 12'h3C3);
  assign romn = key_mode ? 12'hF0F : (an_q ^ 12'h3C3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_pix();
    logic [3:0] v4;
    logic [7:0] h8;
    v4     = v[3:0];
    h8     = h[7:0];
    hcount = h[11:0];
    vcount = v[11:0];
    hblnk  = (h >= 72);
    vblnk  = (v >= 6);
    hsync  = (h >= 74) && (h < 78);
    vsync  = (v == 7);
    rgb    = rgb_fixed ? 12'h123 : ({v4, h8} ^ 12'h800);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    h++;
    if (h == 80) begin
      h = 0;
      v++;
      if (v == 8) v = 0;
    end
    set_pix();
  endtask

  // Advance (at least one pixel) until the inputs show pixel (th, tv).
  task automatic goto(input int th, input int tv);
    int n;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (!(h == th && v == tv) && n < 1300);
    if (n >= 1300) begin
      checks++;
      errors++;
      $display("FAIL goto_timeout: at (%0d,%0d) want (%0d,%0d)", h, v, th, tv);
    end
    #1;
  endtask

  task automatic request(input logic [5:0] x, input logic [5:0] y);
    scroll_x     = x;
    scroll_y     = y;
    scroll_valid = 1'b1;
    next_cycle();
    scroll_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    goto(40, 3);
    request(6'd9, 6'd9);
    checks++;
    if (ready1 !== 1'b0) begin
      errors++; $display("FAIL ready_before_rst: got %b want 0", ready1);
    end
    // Asynchronous reset in the middle of a cycle.
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_hcount1, o_vcount1, o_hsync1, o_vsync1, o_hblnk1, o_vblnk1, o_rgb1, tick1} !== 41'd0) begin
      errors++; $display("FAIL rst_outputs1: got h=%0d v=%0d rgb=%h want all 0", o_hcount1, o_vcount1, o_rgb1);
    end
    checks++;
    if ({o_hcount4, o_vcount4, o_hsync4, o_vsync4, o_hblnk4, o_vblnk4, o_rgb4, tick4} !== 41'd0) begin
      errors++; $display("FAIL rst_outputs4: got h=%0d v=%0d rgb=%h want all 0", o_hcount4, o_vcount4, o_rgb4);
    end
    checks++;
    if (ready1 !== 1'b1) begin
      errors++; $display("FAIL rst_ready: got %b want 1", ready1);
    end
    next_cycle();
    rst = 1'b0;
    goto(60, 3);
    checks++;
    if (o_rgb1 !== 12'hB3A) begin
      errors++; $display("FAIL rst_enable_off: got %h want b3a", o_rgb1);
    end
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h000) begin
      errors++; $display("FAIL rst_first_addr: got %h want 000", addr1);
    end
    goto(30, 1);
    checks++;
    if (o_rgb1 !== 12'h39F) begin
      errors++; $display("FAIL rst_first_rom_pixel: got %h want 39f", o_rgb1);
    end
  endtask

  task automatic test_scroll();
    goto(20, 2);
    request(6'd5, 6'd2);
    checks++;
    if (ready1 !== 1'b0) begin
      errors++; $display("FAIL scroll_ready_low: got %b want 0", ready1);
    end
    goto(79, 5);
    checks++;
    if (ready1 !== 1'b0) begin
      errors++; $display("FAIL scroll_ready_hold: got %b want 0", ready1);
    end
    goto(1, 6);
    checks++;
    if (ready1 !== 1'b1) begin
      errors++; $display("FAIL scroll_ready_back: got %b want 1", ready1);
    end
    checks++;
    if (tick1 !== 1'b1) begin
      errors++; $display("FAIL frame_tick_high: got %b want 1", tick1);
    end
    goto(2, 6);
    checks++;
    if (tick1 !== 1'b0) begin
      errors++; $display("FAIL frame_tick_pulse: got %b want 0", tick1);
    end
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h085) begin
      errors++; $display("FAIL scroll_addr_origin: got %h want 085", addr1);
    end
    goto(30, 0);
    checks++;
    if (o_rgbn !== 12'h81C) begin
      errors++; $display("FAIL rectn_above_vmin: got %h want 81c", o_rgbn);
    end
    goto(60, 0);
    checks++;
    if (addr1 !== 12'h081) begin
      errors++; $display("FAIL scroll_col_wrap: got %h want 081", addr1);
    end
    goto(5, 1);
    checks++;
    if (o_rgbn !== 12'h903) begin
      errors++; $display("FAIL rectn_left_of_hmin: got %h want 903", o_rgbn);
    end
    goto(6, 1);
    checks++;
    if (o_rgbn !== 12'h346) begin
      errors++; $display("FAIL rectn_at_hmin: got %h want 346", o_rgbn);
    end
    goto(30, 1);
    checks++;
    if (o_rgb1 !== 12'h322) begin
      errors++; $display("FAIL scroll_pixel1: got %h want 322", o_rgb1);
    end
    checks++;
    if (o_rgbn !== 12'h35E) begin
      errors++; $display("FAIL scroll_pixeln: got %h want 35e", o_rgbn);
    end
  endtask

  task automatic test_fb_handshake();
    goto(0, 6);
    request(6'd3, 6'd1);
    checks++;
    if (ready1 !== 1'b0) begin
      errors++; $display("FAIL fbhs_ready_low: got %b want 0", ready1);
    end
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h085) begin
      errors++; $display("FAIL fbhs_not_yet: got %h want 085", addr1);
    end
    goto(2, 6);
    checks++;
    if (ready1 !== 1'b1) begin
      errors++; $display("FAIL fbhs_ready_back: got %b want 1", ready1);
    end
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h043) begin
      errors++; $display("FAIL fbhs_applied: got %h want 043", addr1);
    end
  endtask

  task automatic test_auto_scroll();
    goto(10, 1);
    request(6'd0, 6'd0);
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h000) begin
      errors++; $display("FAIL auto_start: got %h want 000", addr1);
    end
    auto_dx = 4'b1111;
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h03F) begin
      errors++; $display("FAIL auto_step1: got %h want 03f", addr1);
    end
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h03E) begin
      errors++; $display("FAIL auto_step2: got %h want 03e", addr1);
    end
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h03D) begin
      errors++; $display("FAIL auto_step3: got %h want 03d", addr1);
    end
    goto(10, 2);
    request(6'd10, 6'd0);
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h00A) begin
      errors++; $display("FAIL auto_suppressed: got %h want 00a", addr1);
    end
    auto_dx = 4'd7;
    auto_dy = 4'd7;
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h1D1) begin
      errors++; $display("FAIL auto_positive: got %h want 1d1", addr1);
    end
    auto_dx = 4'd0;
    auto_dy = 4'b1000;
    goto(0, 0);
    checks++;
    if (addr1 !== 12'hFD1) begin
      errors++; $display("FAIL auto_y_wrap_neg: got %h want fd1", addr1);
    end
    auto_dy = 4'd0;
    goto(10, 1);
    request(6'd0, 6'd0);
    goto(0, 0);
    checks++;
    if (addr1 !== 12'h000) begin
      errors++; $display("FAIL auto_restore: got %h want 000", addr1);
    end
  endtask

  task automatic test_latency();
    goto(30, 1);
    checks++;
    if (o_hcount1 !== 12'd28 || o_vcount1 !== 12'd1) begin
      errors++; $display("FAIL lat1_counts: got %0d,%0d want 28,1", o_hcount1, o_vcount1);
    end
    checks++;
    if (o_hcount4 !== 12'd25 || o_vcount4 !== 12'd1) begin
      errors++; $display("FAIL lat4_counts: got %0d,%0d want 25,1", o_hcount4, o_vcount4);
    end
    checks++;
    if (o_rgb1 !== 12'h39F) begin
      errors++; $display("FAIL lat1_rgb: got %h want 39f", o_rgb1);
    end
    checks++;
    if (o_rgb4 !== 12'h39A) begin
      errors++; $display("FAIL lat4_rgb: got %h want 39a", o_rgb4);
    end
    goto(76, 1);
    checks++;
    if (o_hblnk1 !== 1'b1 || o_hsync1 !== 1'b1 || o_rgb1 !== 12'h000) begin
      errors++; $display("FAIL lat1_hblank: got hb=%b hs=%b rgb=%h want 1 1 000", o_hblnk1, o_hsync1, o_rgb1);
    end
    checks++;
    if (o_hblnk4 !== 1'b0 || o_rgb4 !== 12'h947) begin
      errors++; $display("FAIL lat4_past_hmax: got hb=%b rgb=%h want 0 947", o_hblnk4, o_rgb4);
    end
    goto(71, 2);
    checks++;
    if (o_rgb1 !== 12'h346) begin
      errors++; $display("FAIL rect_last_col: got %h want 346", o_rgb1);
    end
    goto(72, 2);
    checks++;
    if (o_rgb1 !== 12'hA46) begin
      errors++; $display("FAIL rect_at_hmax: got %h want a46", o_rgb1);
    end
    goto(3, 6);
    checks++;
    if (o_vblnk1 !== 1'b1 || o_vcount1 !== 12'd6 || o_rgb1 !== 12'h000) begin
      errors++; $display("FAIL lat1_vblank: got vb=%b v=%0d rgb=%h want 1 6 000", o_vblnk1, o_vcount1, o_rgb1);
    end
    goto(2, 7);
    checks++;
    if (o_vsync1 !== 1'b1) begin
      errors++; $display("FAIL lat1_vsync: got %b want 1", o_vsync1);
    end
    checks++;
    if (o_hcount4 !== 12'd77 || o_vcount4 !== 12'd6 || o_vsync4 !== 1'b0 || o_hsync4 !== 1'b1) begin
      errors++; $display("FAIL lat4_line_wrap: got h=%0d v=%0d vs=%b hs=%b want 77 6 0 1", o_hcount4, o_vcount4, o_vsync4, o_hsync4);
    end
  endtask

  task automatic test_transparency();
    rgb_fixed = 1'b1;
    key_mode  = 1'b1;
    goto(30, 2);
    checks++;
    if (o_rgb1 !== 12'h123) begin
      errors++; $display("FAIL key_transparent1: got %h want 123", o_rgb1);
    end
    checks++;
    if (o_rgb4 !== 12'h123) begin
      errors++; $display("FAIL key_transparent4: got %h want 123", o_rgb4);
    end
    checks++;
    if (o_rgbn !== 12'hF0F) begin
      errors++; $display("FAIL key_opaque_n: got %h want f0f", o_rgbn);
    end
    key_mode = 1'b0;
    enable   = 1'b0;
    goto(50, 3);
    checks++;
    if (o_rgb1 !== 12'h333) begin
      errors++; $display("FAIL enable_midframe_hold: got %h want 333", o_rgb1);
    end
    goto(30, 0);
    checks++;
    if (o_rgb1 !== 12'h123) begin
      errors++; $display("FAIL enable_off_applied: got %h want 123", o_rgb1);
    end
    enable = 1'b1;
    goto(50, 1);
    checks++;
    if (o_rgb1 !== 12'h123) begin
      errors++; $display("FAIL enable_on_midframe_hold: got %h want 123", o_rgb1);
    end
    goto(30, 1);
    checks++;
    if (o_rgb1 !== 12'h39F) begin
      errors++; $display("FAIL enable_on_applied: got %h want 39f", o_rgb1);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    h            = 0;
    v            = 0;
    rgb_fixed    = 1'b0;
    key_mode     = 1'b0;
    rst          = 1'b1;
    scroll_x     = '0;
    scroll_y     = '0;
    scroll_valid = 1'b0;
    auto_dx      = '0;
    auto_dy      = '0;
    enable       = 1'b1;
    set_pix();

    test_reset();
    test_scroll();
    test_fb_handshake();
    test_auto_scroll();
    test_latency();
    test_transparency();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
